// File: rtl/alu_seq_n.sv
// alu_seq_n: key-stepped sequential ALU.
// A debounced step key (CLKb) walks a three-state sequence: LOAD_A captures
// operand A and the operation, LOAD_B computes the result against the live
// INPUT bus and holds it, and DONE waits for the next key press.
//
// The next operation can start from DONE in one of two ways:
//   - ACC=0: load A from INPUT.
//   - ACC=1: chain the held result into A.
//
// Ports:
//   CLK50M     in   sole clock (rising edge)
//   RSTb       in   asynchronous active-low reset
//   CLKb       in   debounced step key, level; synchronised internally
//   INPUT      in   N-bit shared operand bus (A in LOAD_A, B in LOAD_B)
//   ALUcontrol in   3-bit operation select, captured together with A
//   ACC        in   accumulate mode, sampled only on the DONE step
//   CLR        in   synchronous clear of sequence state (OPCNT kept)
//   A          out  held A operand
//   Cout       out  held result
//   V/C/Neg/Z  out  held overflow / carry / negative / zero flags
//   STATE      out  00 LOAD_A, 01 LOAD_B, 10 DONE
//   DONE       out  high while in DONE
//   OPCNT      out  CNTW-bit count of completed operations (wraps)
module alu_seq_n #(
  parameter int N    = 8,
  parameter int CNTW = 8
) (
  input  logic            CLK50M,
  input  logic            RSTb,
  input  logic            CLKb,
  input  logic [N-1:0]    INPUT,
  input  logic [2:0]      ALUcontrol,
  input  logic            ACC,
  input  logic            CLR,
  output logic [N-1:0]    A,
  output logic [N-1:0]    Cout,
  output logic            V,
  output logic            C,
  output logic            Neg,
  output logic            Z,
  output logic [1:0]      STATE,
  output logic            DONE,
  output logic [CNTW-1:0] OPCNT
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'b00,
    ST_LOAD_B = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  state_t state, state_next;

  logic s1, s2, s3;
  logic sync_live, armed;
  logic step;

  logic [N-1:0]    a_reg, cout_reg;
  logic [2:0]      op_reg;
  logic            v_reg, c_reg, neg_reg, z_reg;
  logic [CNTW-1:0] opcnt_reg;

  logic            load_a, load_from_cout, commit;

  logic [N-1:0]    alu_res;
  logic            alu_c, alu_v;
  logic [N:0]      wide;
  logic [SW-1:0]   sh;

  // Key synchroniser and rising-edge detector.
  // This chain also runs during CLR, so a key still held when CLR releases
  // has already been seen and cannot produce a step afterwards.
  // 'armed' requires a genuine low sample of the key after reset before any
  // step is accepted. This stops a key held across reset release from being
  // mistaken for a press.
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      sync_live <= 1'b0;
      armed     <= 1'b0;
    end else begin
      s1        <= CLKb;
      s2        <= s1;
      s3        <= s2;
      sync_live <= 1'b1;
      armed     <= armed | (sync_live & ~s1);
    end
  end

  assign step = s2 & ~s3 & armed;

  // Combinational ALU on the held A, the held op and the live INPUT as B.
  // Both shifts use an N+1 bit window so the extra bit holds the last bit
  // shifted out. That bit is zero when the shift amount is zero.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sh      = INPUT[SW-1:0];
    case (op_reg)
      3'b000: begin
        wide    = {1'b0, a_reg} + {1'b0, INPUT};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (a_reg[N-1] == INPUT[N-1]) && (alu_res[N-1] != a_reg[N-1]);
      end
      3'b001: begin
        wide    = {1'b0, a_reg} - {1'b0, INPUT};
        alu_res = wide[N-1:0];
        alu_c   = ~wide[N];
        alu_v   = (a_reg[N-1] != INPUT[N-1]) && (alu_res[N-1] != a_reg[N-1]);
      end
      3'b010: alu_res = a_reg & INPUT;
      3'b011: alu_res = a_reg | INPUT;
      3'b100: alu_res = a_reg ^ INPUT;
      3'b101: begin
        wide    = {1'b0, a_reg} << sh;
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
      end
      3'b110: begin
        wide    = {a_reg, 1'b0} >> sh;
        alu_res = wide[N:1];
        alu_c   = wide[0];
      end
      default: alu_res = INPUT;
    endcase
  end

  // State register.
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      state <= ST_LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath enables.
  // CLR wins over a coincident step, and that step is dropped.
  // The unused encoding 11 recovers to LOAD_A.
  always_comb begin
    state_next     = state;
    load_a         = 1'b0;
    load_from_cout = 1'b0;
    commit         = 1'b0;
    if (CLR) begin
      state_next = ST_LOAD_A;
    end else if (step) begin
      case (state)
        ST_LOAD_A: begin
          load_a     = 1'b1;
          state_next = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          commit     = 1'b1;
          state_next = ST_DONE;
        end
        ST_DONE: begin
          load_a         = 1'b1;
          load_from_cout = ACC;
          state_next     = ST_LOAD_B;
        end
        default: state_next = ST_LOAD_A;
      endcase
    end
  end

  // Operand, result, flag and completed-operation registers.
  // OPCNT survives CLR; only reset returns it to zero.
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      a_reg     <= '0;
      op_reg    <= 3'b000;
      cout_reg  <= '0;
      v_reg     <= 1'b0;
      c_reg     <= 1'b0;
      neg_reg   <= 1'b0;
      z_reg     <= 1'b0;
      opcnt_reg <= '0;
    end else if (CLR) begin
      a_reg    <= '0;
      op_reg   <= 3'b000;
      cout_reg <= '0;
      v_reg    <= 1'b0;
      c_reg    <= 1'b0;
      neg_reg  <= 1'b0;
      z_reg    <= 1'b0;
    end else begin
      if (load_a) begin
        a_reg  <= load_from_cout ? cout_reg : INPUT;
        op_reg <= ALUcontrol;
      end
      if (commit) begin
        cout_reg  <= alu_res;
        v_reg     <= alu_v;
        c_reg     <= alu_c;
        neg_reg   <= alu_res[N-1];
        z_reg     <= (alu_res == '0);
        opcnt_reg <= opcnt_reg + 1'b1;
      end
    end
  end

  assign A     = a_reg;
  assign Cout  = cout_reg;
  assign V     = v_reg;
  assign C     = c_reg;
  assign Neg   = neg_reg;
  assign Z     = z_reg;
  assign STATE = state;
  assign DONE  = (state == ST_DONE);
  assign OPCNT = opcnt_reg;

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed self-checking bench for alu_seq_n with N=8, CNTW=8.
// Every expected value below is worked out by hand from the operation
// definitions.
module tb_alu_seq_n;

  logic       CLK50M;
  logic       RSTb;
  logic       CLKb;
  logic [7:0] INPUT;
  logic [2:0] ALUcontrol;
  logic       ACC;
  logic       CLR;
  logic [7:0] A;
  logic [7:0] Cout;
  logic       V, C, Neg, Z;
  logic [1:0] STATE;
  logic       DONE;
  logic [7:0] OPCNT;

  int compared   = 0;
  int mismatched = 0;
  int exp_opcnt  = 0;

  alu_seq_n #(.N(8), .CNTW(8)) dut (
    .CLK50M    (CLK50M),
    .RSTb      (RSTb),
    .CLKb      (CLKb),
    .INPUT     (INPUT),
    .ALUcontrol(ALUcontrol),
    .ACC       (ACC),
    .CLR       (CLR),
    .A         (A),
    .Cout      (Cout),
    .V         (V),
    .C         (C),
    .Neg       (Neg),
    .Z         (Z),
    .STATE     (STATE),
    .DONE      (DONE),
    .OPCNT     (OPCNT)
  );

  // 50 MHz clock.
  initial begin
    CLK50M = 1'b0;
    forever #10 CLK50M = ~CLK50M;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Checks the held result, the flags packed as {V,C,Neg,Z}, and the counter.
  task automatic checkResult(input string tag, input logic [7:0] exp_cout,
                             input logic [3:0] exp_flags);
    checkOutput({tag, ".cout"}, {24'd0, Cout}, {24'd0, exp_cout});
    checkOutput({tag, ".flags"}, {28'd0, V, C, Neg, Z}, {28'd0, exp_flags});
    checkOutput({tag, ".opcnt"}, {24'd0, OPCNT}, exp_opcnt);
    checkOutput({tag, ".done"}, {31'd0, DONE}, 32'd1);
  endtask

  // One full key press.
  // The key is raised at a negedge and held until the step has committed
  // (third rising edge). It is then released long enough to re-arm the
  // edge detector.
  task automatic applyStimulus(input logic [7:0] value, input logic [2:0] ctrl,
                               input logic acc);
    @(negedge CLK50M);
    INPUT      = value;
    ALUcontrol = ctrl;
    ACC        = acc;
    CLKb       = 1'b1;
    repeat (3) @(posedge CLK50M);
    #1;
    @(negedge CLK50M);
    CLKb = 1'b0;
    repeat (2) @(negedge CLK50M);
  endtask

  // Load operand A, then apply B, updating the expected operation count.
  task automatic runOp(input logic [7:0] a_val, input logic [2:0] ctrl,
                       input logic [7:0] b_val);
    applyStimulus(a_val, ctrl, 1'b0);
    applyStimulus(b_val, 3'b000, 1'b0);
    exp_opcnt++;
  endtask

  initial begin
    RSTb       = 1'b0;
    CLKb       = 1'b0;
    INPUT      = 8'h00;
    ALUcontrol = 3'b000;
    ACC        = 1'b0;
    CLR        = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLK50M);
    checkOutput("rst.state", {30'd0, STATE}, 32'd0);
    checkOutput("rst.a", {24'd0, A}, 32'd0);
    checkOutput("rst.cout", {24'd0, Cout}, 32'd0);
    checkOutput("rst.flags", {28'd0, V, C, Neg, Z}, 32'd0);
    checkOutput("rst.done", {31'd0, DONE}, 32'd0);
    checkOutput("rst.opcnt", {24'd0, OPCNT}, 32'd0);
    RSTb = 1'b1;
    repeat (3) @(negedge CLK50M);

    // ADD 0x7F + 0x01 with latency check.
    // The key is first sampled at edge k, and the state must still be
    // LOAD_A just after edge k+1.
    INPUT      = 8'h7F;
    ALUcontrol = 3'b000;
    CLKb       = 1'b1;
    @(posedge CLK50M);
    @(posedge CLK50M);
    #1;
    checkOutput("lat.k1.state", {30'd0, STATE}, 32'd0);
    @(posedge CLK50M);
    #1;
    checkOutput("lat.k2.state", {30'd0, STATE}, 32'd1);
    checkOutput("lat.k2.a", {24'd0, A}, 32'h7F);
    @(negedge CLK50M);
    CLKb = 1'b0;
    repeat (2) @(negedge CLK50M);
    applyStimulus(8'h01, 3'b000, 1'b0);
    exp_opcnt++;
    checkResult("add7f01", 8'h80, 4'b1010);
    checkOutput("add7f01.state", {30'd0, STATE}, 32'd2);

    // SUB equal operands, SUB with borrow, SUB with signed overflow.
    runOp(8'h05, 3'b001, 8'h05);
    checkResult("sub0505", 8'h00, 4'b0101);
    runOp(8'h00, 3'b001, 8'h01);
    checkResult("sub0001", 8'hFF, 4'b0010);
    runOp(8'h80, 3'b001, 8'h01);
    checkResult("sub8001", 8'h7F, 4'b1100);

    // Accumulate chain: 0x10+0x20=0x30, then chain it as A and add 0x05.
    runOp(8'h10, 3'b000, 8'h20);
    checkResult("acc1", 8'h30, 4'b0000);
    applyStimulus(8'hAA, 3'b000, 1'b1);
    checkOutput("acc.a", {24'd0, A}, 32'h30);
    checkOutput("acc.state", {30'd0, STATE}, 32'd1);
    applyStimulus(8'h05, 3'b000, 1'b0);
    exp_opcnt++;
    checkResult("acc2", 8'h35, 4'b0000);

    // Shifts.
    runOp(8'h81, 3'b101, 8'h01);
    checkResult("sll8101", 8'h02, 4'b0100);
    runOp(8'h96, 3'b110, 8'h00);
    checkResult("srl9600", 8'h96, 4'b0010);
    runOp(8'h96, 3'b110, 8'h03);
    checkResult("srl9603", 8'h12, 4'b0100);

    // Logic ops and PASSB.
    runOp(8'hFF, 3'b100, 8'hFF);
    checkResult("xorffff", 8'h00, 4'b0001);
    runOp(8'hF0, 3'b011, 8'h0C);
    checkResult("orf00c", 8'hFC, 4'b0010);
    runOp(8'h12, 3'b111, 8'h5A);
    checkResult("passb5a", 8'h5A, 4'b0000);

    // Key held high for 50 cycles gives exactly one advance.
    @(negedge CLK50M);
    INPUT      = 8'h33;
    ALUcontrol = 3'b010;
    ACC        = 1'b0;
    CLKb       = 1'b1;
    repeat (50) @(posedge CLK50M);
    #1;
    checkOutput("hold.state", {30'd0, STATE}, 32'd1);
    checkOutput("hold.a", {24'd0, A}, 32'h33);
    checkOutput("hold.opcnt", {24'd0, OPCNT}, exp_opcnt);
    @(negedge CLK50M);
    CLKb = 1'b0;
    repeat (3) @(negedge CLK50M);

    // CLR coincident with the commit edge of a LOAD_B step.
    INPUT = 8'h0F;
    CLKb  = 1'b1;
    @(posedge CLK50M);
    @(posedge CLK50M);
    #1;
    CLR = 1'b1;
    @(posedge CLK50M);
    #1;
    CLR = 1'b0;
    checkOutput("clr.state", {30'd0, STATE}, 32'd0);
    checkOutput("clr.a", {24'd0, A}, 32'd0);
    checkOutput("clr.cout", {24'd0, Cout}, 32'd0);
    checkOutput("clr.opcnt", {24'd0, OPCNT}, exp_opcnt);
    repeat (5) @(posedge CLK50M);
    #1;
    checkOutput("clr.nospurious", {30'd0, STATE}, 32'd0);
    @(negedge CLK50M);
    CLKb = 1'b0;
    repeat (3) @(negedge CLK50M);

    // Reset pulsed between edges while in LOAD_B.
    runOp(8'h44, 3'b000, 8'h11);
    checkResult("add4411", 8'h55, 4'b0000);
    applyStimulus(8'h22, 3'b000, 1'b0);
    checkOutput("prerst.state", {30'd0, STATE}, 32'd1);
    @(posedge CLK50M);
    #5;
    RSTb = 1'b0;
    #2;
    checkOutput("async.state", {30'd0, STATE}, 32'd0);
    checkOutput("async.a", {24'd0, A}, 32'd0);
    checkOutput("async.cout", {24'd0, Cout}, 32'd0);
    checkOutput("async.opcnt", {24'd0, OPCNT}, 32'd0);
    exp_opcnt = 0;

    // Key already high at reset release gives no step.
    CLKb = 1'b1;
    @(negedge CLK50M);
    RSTb = 1'b1;
    repeat (6) @(negedge CLK50M);
    checkOutput("relhigh.state", {30'd0, STATE}, 32'd0);
    CLKb = 1'b0;
    repeat (3) @(negedge CLK50M);
    applyStimulus(8'h01, 3'b000, 1'b0);
    checkOutput("postrel.state", {30'd0, STATE}, 32'd1);
    checkOutput("postrel.a", {24'd0, A}, 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_seq_n.md
ALU_SEQ_N -- requirements
Module: alu_seq_n

Interface
REQ-001 Parameter N, 8, operand/result width in bits; legal N ≥ 4.
REQ-002 Parameter CNTW, 8, width of the completed-operation counter.
REQ-003 CLK50M  input  1  sole clock; every register updates on its rising edge.
REQ-004 RSTb  input  1  asynchronous, active-low reset; the block has one clock, and reset asserts asynchronously and releases synchronously to CLK50M.
REQ-005 CLKb  input  1  debounced step key (level); it is synchronised and edge-detected inside the block.
REQ-006 INPUT  input  N  shared operand bus (A in LOAD_A, B in LOAD_B).
REQ-007 ALUcontrol  input  3  operation select, sampled with A.
REQ-008 ACC  input  1  accumulate mode: 1 = chain the previous result into A.
REQ-009 CLR  input  1  synchronous clear of sequence state; ignored while RSTb=0.
REQ-010 A  output  N  held A operand.
REQ-011 Cout  output  N  held result.
REQ-012 V, C, Neg, Z  output  1 each  held status flags.
REQ-013 STATE  output  2  FSM encoding: LOAD_A=00, LOAD_B=01, DONE=10.
REQ-014 DONE  output  1  high only while STATE=DONE.
REQ-015 OPCNT  output  CNTW  count of completed operations.

Function
REQ-016 CLKb passes through two synchroniser flops s1 and s2, then a third flop s3; step = s2 & ~s3.
REQ-017 Step latency: CLKb first sampled high at edge k makes step active after edge k+1; the action commits at edge k+2.
REQ-018 Holding CLKb high produces exactly one step; a new step requires CLKb to return low for at least 1 cycle.
REQ-019 ALUcontrol encoding (A op B): 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SLL (A<<B[s-1:0]), 110 SRL, 111 PASSB, where s = clog2(N).
REQ-020 Arithmetic is modulo 2^N.
REQ-021 ADD flags: C = carry out of bit N-1; V = signed overflow.
REQ-022 SUB flags: C = 1 when A ≥ B unsigned (no borrow); V = signed overflow.
REQ-023 SLL/SRL: C = last bit shifted out, or 0 when the shift amount is 0; V = 0.
REQ-024 Logic ops and PASSB: C = 0 and V = 0.
REQ-025 All ops: Neg = result[N-1]; Z = 1 when result == 0.
REQ-026 B is always the live INPUT value; there is no B register.
REQ-027 Combinational result uses held A, held op and live INPUT.
REQ-028 On step in LOAD_A: A←INPUT, op←ALUcontrol, next state LOAD_B.
REQ-029 On step in LOAD_B: Cout and flags ← ALU result; OPCNT increments (wraps at 2^CNTW); next state DONE.
REQ-030 On step in DONE with ACC=1: A←Cout, op←ALUcontrol, next state LOAD_B.
REQ-031 On step in DONE with ACC=0: A←INPUT, op←ALUcontrol, next state LOAD_B.
REQ-032 ACC is sampled only at the DONE step.
REQ-033 Without a step, every register holds its value.
REQ-034 CLR=1 at an edge: state→LOAD_A; A, Cout, flags and op cleared; OPCNT preserved.
REQ-035 CLR has priority over a coincident step, which is discarded.
REQ-036 The synchroniser chain keeps running during CLR, so no spurious step occurs after CLR releases.

Reset
REQ-037 RSTb=0 asynchronously forces: STATE=LOAD_A, A=0, op=000, Cout=0, V=C=Neg=Z=0, DONE=0, OPCNT=0, s1=s2=s3=0.
REQ-038 Reset asserted mid-sequence abandons the operation, with no partial register update.
REQ-039 The first step after reset release requires a CLKb rising edge; CLKb already high at release produces no step.

Verification
REQ-040 N=8, reset, ADD: step A=0x7F, step B=0x01 -> Cout=0x80, V=1, C=0, Neg=1, Z=0, OPCNT=1, DONE=1, result at edge k+2.
REQ-041 SUB A=0x05, B=0x05 -> Cout=0x00, Z=1, C=1, V=0; SUB A=0x00, B=0x01 -> Cout=0xFF, C=0, Neg=1.
REQ-042 ACC=1 chain: ADD 0x10+0x20 -> 0x30; third step with ADD; fourth step B=0x05 -> A=0x30, Cout=0x35, OPCNT=2.
REQ-043 SLL A=0x81, B=0x01 -> Cout=0x02, C=1; SRL with B=0x00 -> Cout=A, C=0; XOR A=0xFF, B=0xFF -> Z=1.
REQ-044 CLKb held high 50 cycles -> exactly one state advance; CLR coincident with step in LOAD_B -> STATE=LOAD_A, OPCNT unchanged.
REQ-045 RSTb pulsed low in LOAD_B between edges -> all outputs reset immediately, before the next clock edge.
